// File: rtl/branch_sequencer.sv
// Multi-cycle branch sequencer: captures a branch request, evaluates CON, forms the target, issues the PC load.
// Optional taken-branch counter enabled by defining BRANCH_SEQ_CNT_EN.
module branch_sequencer #(
   parameter int OFFSET_W = 19
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic [3:0]          c2,
   input  logic [31:0]         ra_value,
   input  logic [31:0]         pc,
   input  logic [OFFSET_W-1:0] offset,
   output logic                busy,
   output logic                con_q,
   output logic                pc_ld,
   output logic [31:0]         pc_out,
   output logic                done
`ifdef BRANCH_SEQ_CNT_EN
   ,
   output logic [15:0]         taken_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EVAL   = 3'd1,
      S_ADDR   = 3'd2,
      S_UPDATE = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t              r_state;
   logic [1:0]          r_cond_sel;
   logic [31:0]         r_ra;
   logic [31:0]         r_pc;
   logic [OFFSET_W-1:0] r_offset;
   logic                r_busy;
   logic                r_con;
   logic                r_pc_ld;
   logic [31:0]         r_target;
   logic                r_done;

   logic                w_cond;
   logic [31:0]         w_offset_sext;
   logic                w_unused_c2;

   // Only the low two bits of the condition field select a test.
   assign w_unused_c2   = ^c2[3:2];
   assign w_offset_sext = 32'(signed'(r_offset));

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves w_cond unassigned (no latch).
      w_cond = 1'b0;
      case (r_cond_sel)
         2'b00: w_cond = (r_ra == 32'd0);
         2'b01: w_cond = (r_ra != 32'd0);
         2'b10: w_cond = ~r_ra[31];
         2'b11: w_cond = r_ra[31];
         default: w_cond = 1'b0;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values; clr clears all state asynchronously.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state    <= S_IDLE;
         r_cond_sel <= 2'b00;
         r_ra       <= 32'd0;
         r_pc       <= 32'd0;
         r_offset   <= '0;
         r_busy     <= 1'b0;
         r_con      <= 1'b0;
         r_pc_ld    <= 1'b0;
         r_target   <= 32'd0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cond_sel <= c2[1:0];
                  r_ra       <= ra_value;
                  r_pc       <= pc;
                  r_offset   <= offset;
                  r_busy     <= 1'b1;
                  r_state    <= S_EVAL;
               end
            end
            S_EVAL: begin
               r_con   <= w_cond;
               r_state <= S_ADDR;
            end
            S_ADDR: begin
               r_target <= r_pc + w_offset_sext;
               // Load enable is registered so it is high exactly while in UPDATE.
               r_pc_ld  <= r_con;
               r_state  <= S_UPDATE;
            end
            S_UPDATE: begin
               r_pc_ld <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_FIN;
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_pc_ld <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign con_q  = r_con;
   assign pc_ld  = r_pc_ld;
   assign pc_out = r_target;
   assign done   = r_done;

`ifdef BRANCH_SEQ_CNT_EN
   logic [15:0] r_taken_cnt;

   // Counts taken branches in their UPDATE cycle; saturates instead of wrapping.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_taken_cnt <= 16'd0;
      end else if (r_state == S_UPDATE && r_con && r_taken_cnt != 16'hFFFF) begin
         r_taken_cnt <= r_taken_cnt + 16'd1;
      end
   end

   assign taken_cnt = r_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed table, hand-written corner sequences, random ops vs. a reference model.
module tb_branch_sequencer;

   logic        clk;
   logic        clr;
   logic        start;
   logic [3:0]  c2;
   logic [31:0] ra_value;
   logic [31:0] pc;
   logic [18:0] offset;
   logic        busy;
   logic        con_q;
   logic        pc_ld;
   logic [31:0] pc_out;
   logic        done;
`ifdef BRANCH_SEQ_CNT_EN
   logic [15:0] taken_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cnt_model = 0;

   branch_sequencer #(.OFFSET_W(19)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .c2       (c2),
      .ra_value (ra_value),
      .pc       (pc),
      .offset   (offset),
      .busy     (busy),
      .con_q    (con_q),
      .pc_ld    (pc_ld),
      .pc_out   (pc_out),
      .done     (done)
`ifdef BRANCH_SEQ_CNT_EN
      ,
      .taken_cnt(taken_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: the branch condition written as plain comparisons on the signed register value.
   function automatic logic model_taken(input logic [3:0] c, input logic [31:0] ra);
      int signed v;
      v = $signed(ra);
      case (c[1:0])
         2'd0:    return v == 0;
         2'd1:    return v != 0;
         2'd2:    return v >= 0;
         default: return v < 0;
      endcase
   endfunction

   function automatic logic [31:0] model_target(input logic [31:0] p, input logic [18:0] off);
      int signed o;
      o = (off >= 19'h40000) ? (int'(off) - (1 << 19)) : int'(off);
      return p + 32'(o);
   endfunction

   function automatic void count_taken(input int n);
      for (int i = 0; i < n; i++)
         if (cnt_model < 65535) cnt_model++;
   endfunction

   task automatic check_cnt(input string name);
`ifdef BRANCH_SEQ_CNT_EN
      check(name, 32'(taken_cnt), 32'(cnt_model));
`endif
   endtask

   // Launch one branch from IDLE (called at a negedge) and check every cycle of its timeline.
   task automatic run_op(input logic [3:0] c, input logic [31:0] ra, input logic [31:0] p,
                         input logic [18:0] off, input bit restart);
      logic        exp_con;
      logic [31:0] exp_tgt;
      int          n_ld;
      int          n_done;
      exp_con  = model_taken(c, ra);
      exp_tgt  = model_target(p, off);
      c2       = c;
      ra_value = ra;
      pc       = p;
      offset   = off;
      start    = 1'b1;
      n_ld     = 0;
      n_done   = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            start    = restart;
            c2       = 4'($urandom);
            ra_value = $urandom;
            pc       = $urandom;
            offset   = 19'($urandom);
         end else begin
            start = 1'b0;
         end
         if (pc_ld) n_ld++;
         if (done) n_done++;
         case (k)
            0: check("busy_rise", 32'(busy), 32'd1);
            1: check("con_q", 32'(con_q), 32'(exp_con));
            2: begin
               check("pc_out", pc_out, exp_tgt);
               check("pc_ld", 32'(pc_ld), 32'(exp_con));
            end
            3: begin
               check("done", 32'(done), 32'd1);
               check("busy_fin", 32'(busy), 32'd1);
            end
            default: begin
               check("busy_idle", 32'(busy), 32'd0);
               check("con_hold", 32'(con_q), 32'(exp_con));
               check("pc_hold", pc_out, exp_tgt);
            end
         endcase
      end
      check("n_pc_ld", 32'(n_ld), 32'(exp_con));
      check("n_done", 32'(n_done), 32'd1);
      if (exp_con) count_taken(1);
      check_cnt("taken_cnt");
   endtask

   typedef struct {
      logic [3:0]  c;
      logic [31:0] ra;
      logic [31:0] p;
      logic [18:0] off;
      logic        exp_con;
      logic [31:0] exp_tgt;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int n_ld;
      int n_done;
      logic [3:0]  rc;
      logic [31:0] rra;

      vecs[0] = '{4'b0000, 32'h0000_0000, 32'h0000_0010, 19'd5,       1'b1, 32'h0000_0015};
      vecs[1] = '{4'b0001, 32'h0000_0000, 32'h0000_0100, 19'h00020,   1'b0, 32'h0000_0120};
      vecs[2] = '{4'b0010, 32'h0000_0007, 32'h0000_0002, 19'h7FFFC,   1'b1, 32'hFFFF_FFFE};
      vecs[3] = '{4'b0011, 32'h8000_0000, 32'h0000_1000, 19'h7FFF0,   1'b1, 32'h0000_0FF0};
      vecs[4] = '{4'b1110, 32'h8000_0000, 32'hFFFF_FFF0, 19'h00020,   1'b0, 32'h0000_0010};
      vecs[5] = '{4'b0011, 32'h0000_0001, 32'h0000_0000, 19'h3FFFF,   1'b0, 32'h0003_FFFF};
      vecs[6] = '{4'b1000, 32'h0000_0000, 32'h7FFF_FFFF, 19'h00001,   1'b1, 32'h8000_0000};

      clr = 1'b0; start = 1'b0; c2 = '0; ra_value = '0; pc = '0; offset = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_con_q", 32'(con_q), 32'd0);
      check("rst_pc_ld", 32'(pc_ld), 32'd0);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_cnt("rst_taken_cnt");
      clr = 1'b1;
      @(negedge clk);

      // Directed table; expected values are hand-derived constants, cross-checked against the model.
      foreach (vecs[i]) begin
         check("tbl_model_con", 32'(model_taken(vecs[i].c, vecs[i].ra)), 32'(vecs[i].exp_con));
         check("tbl_model_tgt", model_target(vecs[i].p, vecs[i].off), vecs[i].exp_tgt);
         run_op(vecs[i].c, vecs[i].ra, vecs[i].p, vecs[i].off, 1'b0);
      end

      // Negative condition with start re-pulsed while in EVAL.
      run_op(4'b0011, 32'h8000_0000, 32'h0000_0200, 19'h00010, 1'b1);

      // start held high: one operation per 5 cycles.
      c2 = 4'b0010; ra_value = 32'd5; pc = 32'h40; offset = 19'd8; start = 1'b1;
      n_ld = 0; n_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 9) start = 1'b0;
         if (pc_ld) n_ld++;
         if (done) n_done++;
         if (pc_ld && done) check("ld_done_overlap", 32'd1, 32'd0);
      end
      check("hold_n_done", 32'(n_done), 32'd2);
      check("hold_n_ld", 32'(n_ld), 32'd2);
      check("hold_pc_out", pc_out, 32'h48);
      check("hold_idle", 32'(busy), 32'd0);
      count_taken(2);
      check_cnt("hold_taken_cnt");

      // Reset while in ADDR aborts the branch.
      c2 = 4'b0000; ra_value = 32'd0; pc = 32'h1234; offset = 19'd4; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_con_q", 32'(con_q), 32'd0);
      check("abort_pc_ld", 32'(pc_ld), 32'd0);
      check("abort_pc_out", pc_out, 32'd0);
      check("abort_done", 32'(done), 32'd0);
      cnt_model = 0;
      check_cnt("abort_taken_cnt");
      @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      n_ld = 0; n_done = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (pc_ld) n_ld++;
         if (done) n_done++;
      end
      check("abort_no_ld", 32'(n_ld), 32'd0);
      check("abort_no_done", 32'(n_done), 32'd0);
      run_op(4'b0000, 32'd0, 32'h0000_0010, 19'd5, 1'b0);

      // Counter: 3 taken, 2 not taken from a cleared state.
      run_op(4'b0000, 32'd0, 32'h10, 19'd1, 1'b0);
      run_op(4'b0001, 32'd0, 32'h10, 19'd2, 1'b0);
      run_op(4'b0011, 32'hFFFF_FFFF, 32'h10, 19'd3, 1'b0);
      run_op(4'b0010, 32'hFFFF_FFFF, 32'h10, 19'd4, 1'b0);
      run_op(4'b0001, 32'd9, 32'h10, 19'd5, 1'b0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         rc  = 4'($urandom);
         rra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op(rc, rra, $urandom, 19'($urandom), 1'($urandom));
      end

`ifdef BRANCH_SEQ_CNT_EN
      force dut.r_taken_cnt = 16'hFFFF;
      #1;
      release dut.r_taken_cnt;
      cnt_model = 65535;
      run_op(4'b0000, 32'd0, 32'h20, 19'd1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
